// File: rtl/axi_ar_arbiter_if.sv
// AR-channel bundle between the read masters, the arbiter and the slave side,
// plus the observed R-channel handshake used to track the active burst.
interface axi_ar_arbiter_if #(
  parameter int NUM_M = 3
);
  logic [NUM_M-1:0]       ARVALID_M;
  logic [NUM_M-1:0][31:0] ARADDR_M;
  logic [NUM_M-1:0][3:0]  ARID_M;
  logic [NUM_M-1:0][3:0]  ARLEN_M;
  logic [NUM_M-1:0]       ARREADY_M;
  logic                   ARVALID_S;
  logic [31:0]            ARADDR_S;
  logic [7:0]             ARID_S;
  logic [3:0]             ARLEN_S;
  logic                   ARREADY_S;
  logic                   RVALID_S;
  logic                   RREADY_S;
  logic                   RLAST_S;

  // Arbiter view: it is the slave of the read masters.
  modport slave (
    input  ARVALID_M, ARADDR_M, ARID_M, ARLEN_M, ARREADY_S,
    input  RVALID_S, RREADY_S, RLAST_S,
    output ARREADY_M, ARVALID_S, ARADDR_S, ARID_S, ARLEN_S
  );

  // Environment view: masters plus the slave/R-channel side.
  modport master (
    output ARVALID_M, ARADDR_M, ARID_M, ARLEN_M, ARREADY_S,
    output RVALID_S, RREADY_S, RLAST_S,
    input  ARREADY_M, ARVALID_S, ARADDR_S, ARID_S, ARLEN_S
  );
endinterface

// File: rtl/axi_ar_arbiter.sv
// Round-robin AR arbiter for NUM_M read masters with a single outstanding
// read transaction system-wide. Tracks R beats of the active burst and
// pulses len_err_o when the observed burst length disagrees with ARLEN.
module axi_ar_arbiter #(
  parameter int NUM_M = 3
) (
  input  logic             ACLK,
  input  logic             ARESETn,
  axi_ar_arbiter_if.slave  bus,
  output logic [NUM_M-1:0] grant_o,
  output logic             busy_o,
  output logic             len_err_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADDR = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;

  logic [1:0]       r_state;
  logic [NUM_M-1:0] r_grant;
  logic [3:0]       r_gidx;
  logic [3:0]       r_last;
  logic [3:0]       r_len;
  logic [3:0]       r_beat;
  logic             r_busy;
  logic             r_len_err;
  logic             r_err_seen;   // a burst reports at most one length error

  logic             w_found;
  logic [3:0]       w_pick;
  logic [NUM_M-1:0] w_pick_oh;
  logic [3:0]       w_pick_len;
  logic             w_g_valid;
  logic [31:0]      w_addr;
  logic [3:0]       w_id;
  logic [3:0]       w_len;
  logic             w_r_hs;

  // Round-robin pick: first requester above last_grant, else wrap to the lowest.
  always_comb begin
    w_found    = 1'b0;
    w_pick     = 4'd0;
    w_pick_oh  = {NUM_M{1'b0}};
    w_pick_len = 4'd0;
    for (int i = 0; i < NUM_M; i++) begin
      if (!w_found && bus.ARVALID_M[i] && (4'(i) > r_last)) begin
        w_found      = 1'b1;
        w_pick       = 4'(i);
        w_pick_oh[i] = 1'b1;
        w_pick_len   = bus.ARLEN_M[i];
      end else begin
        w_found = w_found;
      end
    end
    for (int i = 0; i < NUM_M; i++) begin
      if (!w_found && bus.ARVALID_M[i] && (4'(i) <= r_last)) begin
        w_found      = 1'b1;
        w_pick       = 4'(i);
        w_pick_oh[i] = 1'b1;
        w_pick_len   = bus.ARLEN_M[i];
      end else begin
        w_found = w_found;
      end
    end
  end

  // Select the granted master's request fields (one-hot OR mux).
  always_comb begin
    w_g_valid = 1'b0;
    w_addr    = 32'd0;
    w_id      = 4'd0;
    w_len     = 4'd0;
    for (int i = 0; i < NUM_M; i++) begin
      if (r_grant[i]) begin
        w_g_valid = bus.ARVALID_M[i];
        w_addr    = bus.ARADDR_M[i];
        w_id      = bus.ARID_M[i];
        w_len     = bus.ARLEN_M[i];
      end else begin
        w_g_valid = w_g_valid;
      end
    end
  end

  assign w_r_hs = bus.RVALID_S && bus.RREADY_S;

  // Forward the granted request only while in ADDR; everything else is quiet.
  always_comb begin
    if (r_state == ST_ADDR) begin
      bus.ARVALID_S = w_g_valid;
      bus.ARADDR_S  = w_addr;
      bus.ARID_S    = {r_gidx, w_id};
      bus.ARLEN_S   = w_len;
      bus.ARREADY_M = r_grant & {NUM_M{bus.ARREADY_S}};
    end else begin
      bus.ARVALID_S = 1'b0;
      bus.ARADDR_S  = 32'd0;
      bus.ARID_S    = 8'd0;
      bus.ARLEN_S   = 4'd0;
      bus.ARREADY_M = {NUM_M{1'b0}};
    end
  end

  // Transaction FSM, grant bookkeeping and burst-length checking.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state    <= ST_IDLE;
      r_grant    <= {NUM_M{1'b0}};
      r_gidx     <= 4'd0;
      r_last     <= 4'(NUM_M - 1);
      r_len      <= 4'd0;
      r_beat     <= 4'd0;
      r_busy     <= 1'b0;
      r_len_err  <= 1'b0;
      r_err_seen <= 1'b0;
    end else begin
      r_len_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_state    <= ST_ADDR;
            r_grant    <= w_pick_oh;
            r_gidx     <= w_pick;
            r_len      <= w_pick_len;
            r_beat     <= 4'd0;
            r_busy     <= 1'b1;
            r_err_seen <= 1'b0;
          end
        end
        ST_ADDR: begin
          if (!w_g_valid) begin
            // Master withdrew before the handshake: abandon, keep last_grant.
            r_state <= ST_IDLE;
            r_grant <= {NUM_M{1'b0}};
            r_busy  <= 1'b0;
          end else if (bus.ARREADY_S) begin
            r_state <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_r_hs) begin
            r_beat <= r_beat + 4'd1;
            if (bus.RLAST_S) begin
              r_state   <= ST_IDLE;
              r_last    <= r_gidx;
              r_grant   <= {NUM_M{1'b0}};
              r_busy    <= 1'b0;
              r_len_err <= (r_beat != r_len) && !r_err_seen;
            end else if ((r_beat == r_len) && !r_err_seen) begin
              // Burst overran ARLEN; keep tracking until RLAST arrives.
              r_len_err  <= 1'b1;
              r_err_seen <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_grant <= {NUM_M{1'b0}};
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign grant_o   = r_grant;
  assign busy_o    = r_busy;
  assign len_err_o = r_len_err;

endmodule

// File: tb/tb_axi_ar_arbiter.sv
// Directed bench for axi_ar_arbiter with a transaction-level reference model
// compared against the DUT every cycle, plus hand-computed literal checks.
module tb_axi_ar_arbiter;
  localparam int NUM_M = 3;

  logic             ACLK = 1'b0;
  logic             ARESETn = 1'b0;
  logic [NUM_M-1:0] grant_o;
  logic             busy_o;
  logic             len_err_o;

  int n_checks = 0;
  int n_errors = 0;
  int n_pulses = 0;
  int p0;

  axi_ar_arbiter_if #(.NUM_M(NUM_M)) bus ();

  axi_ar_arbiter #(.NUM_M(NUM_M)) dut (
    .ACLK     (ACLK),
    .ARESETn  (ARESETn),
    .bus      (bus),
    .grant_o  (grant_o),
    .busy_o   (busy_o),
    .len_err_o(len_err_o)
  );

  always #5 ACLK = ~ACLK;

  // Reference model: the current transaction and who won last.
  bit m_active, m_addr_done, m_err_rep, m_pulse;
  int m_master, m_beats, m_len, m_last;

  logic [NUM_M-1:0] e_grant, e_ardy;
  logic             e_arvalid;
  logic [31:0]      e_addr;
  logic [7:0]       e_id;
  logic [3:0]       e_len;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_addr_done = 0; m_err_rep = 0; m_pulse = 0;
    m_master = 0; m_beats = 0; m_len = 0; m_last = NUM_M - 1;
  endtask

  task automatic model_step();
    m_pulse = 0;
    if (!m_active) begin
      for (int k = 1; k <= NUM_M; k++) begin
        int c;
        c = (m_last + k) % NUM_M;
        if (bus.ARVALID_M[c]) begin
          m_active = 1; m_addr_done = 0; m_master = c;
          m_beats = 0; m_len = int'(bus.ARLEN_M[c]); m_err_rep = 0;
          break;
        end
      end
    end else if (!m_addr_done) begin
      if (!bus.ARVALID_M[m_master]) m_active = 0;
      else if (bus.ARREADY_S) m_addr_done = 1;
    end else if (bus.RVALID_S && bus.RREADY_S) begin
      int pos;
      pos = m_beats % 16;
      if (bus.RLAST_S) begin
        if (pos != m_len && !m_err_rep) m_pulse = 1;
        m_active = 0;
        m_last = m_master;
      end else if (pos == m_len && !m_err_rep) begin
        m_pulse = 1;
        m_err_rep = 1;
      end
      m_beats++;
    end
  endtask

  initial model_reset();

  // Model advances on each rising edge with the inputs held across it.
  initial forever begin
    @(posedge ACLK);
    if (!ARESETn) model_reset();
    else model_step();
  end

  // Compare DUT outputs against the model on every falling edge.
  initial forever begin
    @(negedge ACLK);
    if (len_err_o === 1'b1) n_pulses++;
    e_grant = '0; e_ardy = '0; e_arvalid = 1'b0;
    e_addr = 32'd0; e_id = 8'd0; e_len = 4'd0;
    if (ARESETn && m_active) begin
      e_grant[m_master] = 1'b1;
      if (!m_addr_done) begin
        e_arvalid = bus.ARVALID_M[m_master];
        e_addr    = bus.ARADDR_M[m_master];
        e_id      = {4'(m_master), bus.ARID_M[m_master]};
        e_len     = bus.ARLEN_M[m_master];
        e_ardy[m_master] = bus.ARREADY_S;
      end
    end
    check("m_grant",    grant_o,       e_grant);
    check("m_busy",     busy_o,        ARESETn && m_active);
    check("m_len_err",  len_err_o,     ARESETn && m_pulse);
    check("m_arvalid",  bus.ARVALID_S, e_arvalid);
    check("m_araddr",   bus.ARADDR_S,  e_addr);
    check("m_arid",     bus.ARID_S,    e_id);
    check("m_arlen",    bus.ARLEN_S,   e_len);
    check("m_arready",  bus.ARREADY_M, e_ardy);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic await_grant(input logic [NUM_M-1:0] exp, input string name);
    int n;
    n = 0;
    while (grant_o == '0 && n < 10) begin
      tick();
      n++;
    end
    check({name, "_grant"}, grant_o, exp);
  endtask

  task automatic do_beats(input int n, input int rlast_at);
    for (int b = 1; b <= n; b++) begin
      bus.RVALID_S = 1'b1;
      bus.RREADY_S = 1'b1;
      bus.RLAST_S  = (b == rlast_at);
      tick();
    end
    bus.RVALID_S = 1'b0;
    bus.RREADY_S = 1'b0;
    bus.RLAST_S  = 1'b0;
  endtask

  initial begin
    bus.ARVALID_M = '0; bus.ARADDR_M = '0; bus.ARID_M = '0; bus.ARLEN_M = '0;
    bus.ARREADY_S = 1'b0; bus.RVALID_S = 1'b0; bus.RREADY_S = 1'b0; bus.RLAST_S = 1'b0;
    ARESETn = 1'b0;
    repeat (3) tick();
    check("rst_grant",   grant_o,       3'b000);
    check("rst_busy",    busy_o,        1'b0);
    check("rst_len_err", len_err_o,     1'b0);
    check("rst_arvalid", bus.ARVALID_S, 1'b0);
    check("rst_arready", bus.ARREADY_M, 3'b000);
    ARESETn = 1'b1;

    // All three masters requesting: M0, M1, M2, M0 with single-beat bursts.
    bus.ARADDR_M[0] = 32'h0000_1000; bus.ARID_M[0] = 4'h1;
    bus.ARADDR_M[1] = 32'h0000_2000; bus.ARID_M[1] = 4'h2;
    bus.ARADDR_M[2] = 32'h0000_3000; bus.ARID_M[2] = 4'h3;
    bus.ARREADY_S = 1'b1;
    tick();
    bus.ARVALID_M = 3'b111;
    tick();
    check("latency_arvalid", bus.ARVALID_S, 1'b1);
    check("latency_arid",    bus.ARID_S,    8'h01);
    await_grant(3'b001, "rr0"); tick(); do_beats(1, 1);
    await_grant(3'b010, "rr1"); tick(); do_beats(1, 1);
    await_grant(3'b100, "rr2"); tick(); do_beats(1, 1);
    check("rr_bubble_busy", busy_o, 1'b0);
    await_grant(3'b001, "rr3"); tick();
    bus.ARVALID_M = 3'b000;
    do_beats(1, 1);
    tick();

    // M1 with ARREADY_S delayed two cycles.
    bus.ARADDR_M[1] = 32'h0001_0000; bus.ARID_M[1] = 4'h5; bus.ARLEN_M[1] = 4'd3;
    bus.ARREADY_S = 1'b0;
    bus.ARVALID_M = 3'b010;
    p0 = n_pulses;
    tick();
    await_grant(3'b010, "dly");
    check("dly_arvalid0", bus.ARVALID_S, 1'b1);
    check("dly_arid",     bus.ARID_S,    8'h15);
    check("dly_araddr",   bus.ARADDR_S,  32'h0001_0000);
    check("dly_arready0", bus.ARREADY_M, 3'b000);
    tick();
    check("dly_arvalid1", bus.ARVALID_S, 1'b1);
    check("dly_arready1", bus.ARREADY_M, 3'b000);
    tick();
    bus.ARREADY_S = 1'b1;
    #1;
    check("dly_arready_hs", bus.ARREADY_M, 3'b010);
    tick();
    bus.ARREADY_S = 1'b0;
    bus.ARVALID_M = 3'b000;
    #1;
    check("dly_arready_data", bus.ARREADY_M, 3'b000);
    check("dly_arvalid_data", bus.ARVALID_S, 1'b0);
    bus.ARREADY_S = 1'b1;
    do_beats(4, 4);
    tick();
    check("dly_no_err", n_pulses - p0, 0);

    // ARLEN=3 but RLAST on beat 2: one pulse, back to IDLE.
    bus.ARLEN_M[0] = 4'd3;
    bus.ARVALID_M = 3'b001;
    p0 = n_pulses;
    tick(); await_grant(3'b001, "short"); tick();
    bus.ARVALID_M = 3'b000;
    do_beats(2, 2);
    tick();
    check("short_err_pulses", n_pulses - p0, 1);
    check("short_idle",       busy_o, 1'b0);

    // ARLEN=1, two beats without RLAST then RLAST on beat 3.
    bus.ARLEN_M[0] = 4'd1;
    bus.ARVALID_M = 3'b001;
    p0 = n_pulses;
    tick(); await_grant(3'b001, "long"); tick();
    bus.ARVALID_M = 3'b000;
    do_beats(2, 0);
    check("long_stays_data", busy_o, 1'b1);
    do_beats(1, 1);
    tick();
    check("long_err_pulses", n_pulses - p0, 1);
    check("long_idle",       busy_o, 1'b0);

    // 16-beat burst (ARLEN=15) exercises the full counter range, no error.
    bus.ARLEN_M[1] = 4'd15;
    bus.ARVALID_M = 3'b010;
    p0 = n_pulses;
    tick(); await_grant(3'b010, "wrap"); tick();
    bus.ARVALID_M = 3'b000;
    do_beats(16, 16);
    tick();
    check("wrap_no_err", n_pulses - p0, 0);

    // M2 withdraws in ADDR, then still wins the next slot after M1.
    bus.ARLEN_M[2] = 4'd0;
    bus.ARREADY_S = 1'b0;
    bus.ARVALID_M = 3'b100;
    tick(); await_grant(3'b100, "abort"); tick();
    bus.ARVALID_M = 3'b000;
    tick();
    check("abort_busy",  busy_o,  1'b0);
    check("abort_grant", grant_o, 3'b000);
    bus.ARVALID_M = 3'b111;
    bus.ARREADY_S = 1'b1;
    tick(); await_grant(3'b100, "abort_rr"); tick();
    bus.ARVALID_M = 3'b000;
    do_beats(1, 1);
    tick();

    // Reset during DATA abandons the burst; M0 wins first afterwards.
    bus.ARLEN_M[1] = 4'd3;
    bus.ARLEN_M[0] = 4'd0;
    bus.ARVALID_M = 3'b010;
    p0 = n_pulses;
    tick(); await_grant(3'b010, "mid"); tick();
    bus.ARVALID_M = 3'b000;
    do_beats(2, 0);
    ARESETn = 1'b0;
    #1;
    check("mid_rst_grant",   grant_o,       3'b000);
    check("mid_rst_busy",    busy_o,        1'b0);
    check("mid_rst_len_err", len_err_o,     1'b0);
    check("mid_rst_arvalid", bus.ARVALID_S, 1'b0);
    check("mid_rst_arready", bus.ARREADY_M, 3'b000);
    tick(); tick();
    ARESETn = 1'b1;
    bus.ARVALID_M = 3'b111;
    tick(); await_grant(3'b001, "post_rst"); tick();
    bus.ARVALID_M = 3'b000;
    do_beats(1, 1);
    tick(); tick();
    check("post_rst_no_err", n_pulses - p0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/axi_ar_arbiter.md
AXI_AR_ARBITER -- requirements
Module: AXI_AR_arbiter

Interface
REQ-001 Parameter NUM_M, default 3, number of read masters (M0 CPU fetch, M1 CPU data, M2 DMA).
REQ-002 ACLK  input  1  single clock; all state updates on rising edge.
REQ-003 ARESETn  input  1  reset, asynchronous assert, active-low.
REQ-004 ARVALID_M  input  NUM_M  per-master read-address valid.
REQ-005 ARADDR_M  input  NUM_M x 32  per-master read address.
REQ-006 ARID_M  input  NUM_M x 4  per-master transaction ID.
REQ-007 ARLEN_M  input  NUM_M x 4  per-master burst length minus one.
REQ-008 ARREADY_M  output  NUM_M  per-master read-address ready.
REQ-009 ARVALID_S  output  1  arbitrated valid toward the address decoder and slaves.
REQ-010 ARADDR_S  output  32  arbitrated address toward the decoder.
REQ-011 ARID_S  output  8  {granted master index (4 b), ARID of granted master}.
REQ-012 ARLEN_S  output  4  arbitrated burst length.
REQ-013 ARREADY_S  input  1  ready from the selected slave.
REQ-014 RVALID_S, RREADY_S, RLAST_S  input  1 each  observed R-channel handshake of the active burst.
REQ-015 grant_o  output  NUM_M  registered one-hot grant; all-zero when idle.
REQ-016 busy_o  output  1  high in ADDR or DATA state.
REQ-017 len_err_o  output  1  one-cycle pulse on burst-length mismatch.

Function
REQ-018 FSM states IDLE, ADDR, DATA; exactly one read transaction outstanding system-wide.
REQ-019 IDLE: if any ARVALID_M bit set, register grant by round-robin starting at (last_grant+1) mod NUM_M, latch that master's ARLEN_M into len_q, clear beat counter, go ADDR next cycle.
REQ-020 IDLE with no request: stay IDLE; grant_o=0, ARVALID_S=0, all ARREADY_M=0.
REQ-021 ADDR: ARVALID_S = ARVALID_M[g]; ARADDR_S/ARLEN_S/ARID_S muxed combinationally from granted master g; ARREADY_M[g] = ARREADY_S; all other ARREADY_M=0.
REQ-022 ADDR: on ARVALID_S && ARREADY_S go DATA.
REQ-023 ADDR: if ARVALID_M[g] drops before handshake, return IDLE; last_grant unchanged; no error.
REQ-024 Outside ADDR: ARVALID_S=0, ARREADY_M=0; ARADDR_S/ARID_S/ARLEN_S driven 0.
REQ-025 DATA: each RVALID_S && RREADY_S increments 4-bit beat counter.
REQ-026 DATA: handshake with RLAST_S=1 -> IDLE next cycle, last_grant <= g, grant_o cleared.
REQ-027 DATA: len_err_o pulses 1 cycle (registered) when RLAST_S arrives with counter != len_q, or counter == len_q on a handshake without RLAST_S; in the latter case FSM stays DATA until RLAST_S.
REQ-028 Counter wraps 15->0 silently; no extra error beyond REQ-027.
REQ-029 New requests during ADDR/DATA are ignored; evaluated only in IDLE (earliest the cycle after return to IDLE).
REQ-030 Simultaneous RLAST handshake and new ARVALID_M: new grant not made until IDLE cycle (one idle bubble minimum).
REQ-031 Arbitration latency: request in IDLE -> ARVALID_S high next cycle.

Reset
REQ-032 ARESETn low: state IDLE, grant_o=0, busy_o=0, len_err_o=0, beat counter 0, len_q 0, last_grant=NUM_M-1 (M0 wins first), all ARREADY_M=0, ARVALID_S=0, immediately and asynchronously.
REQ-033 Reset mid-burst abandons transaction; no len_err_o pulse after release.

Verification
REQ-034 After reset, ARVALID_M=3'b111 held -> grants M0, M1, M2, M0 in order, one per completed single-beat burst.
REQ-035 M1 ARADDR=0x0001_0000, ARID=4'h5, ARLEN=3, ARREADY_S delayed 2 cycles -> ARVALID_S stays high, ARID_S=8'h15, ARREADY_M=3'b010 in handshake cycle only.
REQ-036 ARLEN=3, RLAST on beat 2 -> len_err_o single pulse, FSM to IDLE.
REQ-037 ARLEN=1, two beats no RLAST then RLAST on beat 3 -> one len_err_o pulse, FSM stays DATA until beat 3.
REQ-038 M2 drops ARVALID in ADDR before ARREADY_S -> IDLE next cycle, M2 re-requesting still gets next round-robin slot after last_grant.
REQ-039 ARESETn low during DATA -> all outputs at REQ-032 values same cycle; post-release M0 granted first.
